// File: rtl/mem_controller_pkg.sv
// Shared load/store size encodings and IO region bit positions for mem_controller.
package mem_controller_pkg;

  localparam logic [1:0] LS_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LS_SIZE_HALF = 2'd1;
  localparam logic [1:0] LS_SIZE_WORD = 2'd2;
  localparam int unsigned LS_SIZE_UNSIGNED_BIT = 2;

  localparam int unsigned IO_REGION_HI_BIT = 17;
  localparam int unsigned IO_REGION_LO_BIT = 16;

  // Index of the final byte of an access; the reserved size 3 behaves as a word.
  function automatic logic [1:0] ls_last_byte(input logic [1:0] size);
    case (size)
      LS_SIZE_BYTE: return 2'd0;
      LS_SIZE_HALF: return 2'd1;
      default:      return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_controller_load_extender.sv
// load_extender: sign- or zero-extends an assembled little-endian load to 32 bits.
module load_extender
  import mem_controller_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [2:0]  i_size,
  output logic [31:0] o_res
);

  logic w_signed;
  assign w_signed = ~i_size[LS_SIZE_UNSIGNED_BIT];

  always_comb begin
    o_res = i_raw;
    case (i_size[1:0])
      LS_SIZE_BYTE: o_res = {{24{w_signed & i_raw[7]}}, i_raw[7:0]};
      LS_SIZE_HALF: o_res = {{16{w_signed & i_raw[15]}}, i_raw[15:0]};
      default:      o_res = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// mem_controller: serialises one sized load/store into byte accesses on the 8-bit RAM/IO bus.
// Define IO_WRITE_STALL_EN to hold IO-region stores while the UART TX buffer is full.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  cache_valid,
  input  logic                  cache_wr,
  input  logic [2:0]            cache_size,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic [31:0]           cache_value,
  output logic                  cache_ready,
  output logic [31:0]           cache_res,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                r_state, w_state;
  logic [2:0]            r_size, w_size;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr, r_mem_a, w_mem_a;
  logic [31:0]           r_value, w_value, r_raw, w_raw, r_res, w_res;
  logic [1:0]            r_last, w_last, r_cnt, w_cnt, r_rd_idx, w_rd_idx;
  logic                  r_iss, w_iss, r_rd_vld, w_rd_vld, r_ready, w_ready;
  logic                  r_mem_wr, w_mem_wr, r_rdy_q;
  logic [7:0]            r_mem_dout, w_mem_dout;
  logic [1:0]            w_cnt_inc;
  logic [31:0]           w_val_next, w_raw_cap, w_ext;
  logic                  w_accept_blk, w_wr_stall;

`ifdef IO_WRITE_STALL_EN
  assign w_accept_blk = cache_wr && io_buffer_full &&
                        (cache_addr[IO_REGION_HI_BIT:IO_REGION_LO_BIT] == IO_BASE_HI);
  assign w_wr_stall   = io_buffer_full && (r_state == StWrite) &&
                        (r_addr[IO_REGION_HI_BIT:IO_REGION_LO_BIT] == IO_BASE_HI);
`else
  logic w_unused_io;
  assign w_unused_io  = io_buffer_full;
  assign w_accept_blk = 1'b0;
  assign w_wr_stall   = 1'b0;
`endif

  assign w_cnt_inc  = r_cnt + 2'd1;
  assign w_val_next = r_value >> {w_cnt_inc, 3'b000};

  always_comb begin
    w_raw_cap = r_raw;
    unique case (r_rd_idx)
      2'd0: w_raw_cap[7:0]   = mem_din;
      2'd1: w_raw_cap[15:8]  = mem_din;
      2'd2: w_raw_cap[23:16] = mem_din;
      2'd3: w_raw_cap[31:24] = mem_din;
    endcase
  end

  load_extender u_load_extender (
    .i_raw  (w_raw_cap),
    .i_size (r_size),
    .o_res  (w_ext)
  );

  always_comb begin
    w_state    = r_state;
    w_size     = r_size;
    w_addr     = r_addr;
    w_value    = r_value;
    w_last     = r_last;
    w_cnt      = r_cnt;
    w_iss      = r_iss;
    w_rd_vld   = r_rd_vld;
    w_rd_idx   = r_rd_idx;
    w_raw      = r_raw;
    w_ready    = r_ready;
    w_res      = r_res;
    w_mem_a    = r_mem_a;
    w_mem_dout = r_mem_dout;
    w_mem_wr   = r_mem_wr;
    if (!rdy_in) begin
      // The completion pulse still retires so cache_ready never stretches across a pause.
      if (r_state == StDone) begin
        w_state = StIdle;
        w_ready = 1'b0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cache_valid && !r_ready && !w_accept_blk) begin
            w_size   = cache_size;
            w_addr   = cache_addr;
            w_value  = cache_value;
            w_last   = ls_last_byte(cache_size[1:0]);
            w_cnt    = 2'd0;
            w_mem_a  = cache_addr;
            w_raw    = 32'd0;
            w_rd_vld = 1'b0;
            if (cache_wr) begin
              w_state    = StWrite;
              w_mem_wr   = 1'b1;
              w_mem_dout = cache_value[7:0];
            end else begin
              w_state = StRead;
              w_iss   = 1'b1;
            end
          end
        end
        StWrite: begin
          if (!w_wr_stall) begin
            if (r_cnt == r_last) begin
              w_mem_wr = 1'b0;
              w_state  = StDone;
              w_ready  = 1'b1;
              w_res    = 32'd0;
            end else begin
              w_cnt      = w_cnt_inc;
              w_mem_a    = r_addr + ADDR_WIDTH'(w_cnt_inc);
              w_mem_dout = w_val_next[7:0];
            end
          end
        end
        StRead: begin
          if (!r_rdy_q) begin
            // Resume bubble: this cycle's mem_din is stale, so refetch any byte still in flight.
            if (r_rd_vld) begin
              w_cnt    = r_rd_idx;
              w_mem_a  = r_addr + ADDR_WIDTH'(r_rd_idx);
              w_iss    = 1'b1;
              w_rd_vld = 1'b0;
            end
          end else begin
            w_rd_vld = r_iss;
            w_rd_idx = r_cnt;
            if (r_iss) begin
              if (r_cnt == r_last) begin
                w_iss = 1'b0;
              end else begin
                w_cnt   = w_cnt_inc;
                w_mem_a = r_addr + ADDR_WIDTH'(w_cnt_inc);
              end
            end
            if (r_rd_vld) begin
              w_raw = w_raw_cap;
              if (r_rd_idx == r_last) begin
                w_state = StDone;
                w_ready = 1'b1;
                w_res   = w_ext;
              end
            end
          end
        end
        StDone: begin
          w_state = StIdle;
          w_ready = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= StIdle;
      r_size     <= 3'd0;
      r_addr     <= '0;
      r_value    <= 32'd0;
      r_last     <= 2'd0;
      r_cnt      <= 2'd0;
      r_iss      <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_idx   <= 2'd0;
      r_raw      <= 32'd0;
      r_ready    <= 1'b0;
      r_res      <= 32'd0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_rdy_q    <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_size     <= w_size;
      r_addr     <= w_addr;
      r_value    <= w_value;
      r_last     <= w_last;
      r_cnt      <= w_cnt;
      r_iss      <= w_iss;
      r_rd_vld   <= w_rd_vld;
      r_rd_idx   <= w_rd_idx;
      r_raw      <= w_raw;
      r_ready    <= w_ready;
      r_res      <= w_res;
      r_mem_a    <= w_mem_a;
      r_mem_dout <= w_mem_dout;
      r_mem_wr   <= w_mem_wr;
      r_rdy_q    <= rdy_in;
    end
  end

  assign cache_ready = r_ready;
  assign cache_res   = r_res;
  assign mem_a       = r_mem_a;
  assign mem_dout    = r_mem_dout;
  assign mem_wr      = r_mem_wr & rdy_in & ~w_wr_stall;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: driver queues expected completions and bus writes,
// a negedge monitor pops and compares them.
module tb_mem_controller;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        cache_valid = 1'b0;
  logic        cache_wr = 1'b0;
  logic [2:0]  cache_size = 3'd0;
  logic [31:0] cache_addr = 32'd0;
  logic [31:0] cache_value = 32'd0;
  logic        cache_ready;
  logic [31:0] cache_res;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  logic [7:0] mem [logic [31:0]];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   timeouts = 0;
  bit   done = 1'b0;
  bit   prev_ready = 1'b0;

  mem_controller #(
    .ADDR_WIDTH (32),
    .IO_BASE_HI (2'b11)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .cache_valid    (cache_valid),
    .cache_wr       (cache_wr),
    .cache_size     (cache_size),
    .cache_addr     (cache_addr),
    .cache_value    (cache_value),
    .cache_ready    (cache_ready),
    .cache_res      (cache_res),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Byte RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_a] = mem_dout;
    mem_din <= mem.exists(mem_a) ? mem[mem_a] : 8'h00;
  end

  always @(negedge clk) begin
    if (rst_in) begin
      checks++;
      if ({cache_ready, cache_res, mem_a, mem_dout, mem_wr} != 74'd0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%0b res=%h a=%h dout=%h wr=%0b, all must be 0",
                 cache_ready, cache_res, mem_a, mem_dout, mem_wr);
      end
      prev_ready = 1'b0;
    end else begin
      if (cache_ready) begin
        checks++;
        if (prev_ready) begin
          errors++;
          $display("FAIL ready_pulse: cache_ready high two cycles in a row at cycle %0d", cyc);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ready_unexpected: cache_ready at cycle %0d res=%h, none expected",
                   cyc, cache_res);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cache_res != e.res) begin
            errors++;
            $display("FAIL ready_res: got %h expected %h", cache_res, e.res);
          end
          if (e.cyc >= 0) begin
            checks++;
            if (cyc != e.cyc) begin
              errors++;
              $display("FAIL ready_cycle: got cycle %0d expected %0d", cyc, e.cyc);
            end
          end
        end
      end
      if (mem_wr) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: cycle %0d a=%h d=%h, none expected",
                   cyc, mem_a, mem_dout);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (cyc != w.cyc || mem_a != w.a || mem_dout != w.d) begin
            errors++;
            $display("FAIL write: got cycle %0d a=%h d=%h expected cycle %0d a=%h d=%h",
                     cyc, mem_a, mem_dout, w.cyc, w.a, w.d);
          end
        end
      end
      prev_ready = cache_ready;
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_ready: %0d completions never seen, expected 0", exp_q.size());
      end
      checks++;
      if (wr_q.size() != 0) begin
        errors++;
        $display("FAIL pending_write: %0d writes never seen, expected 0", wr_q.size());
      end
      checks++;
      if (timeouts != 0) begin
        errors++;
        $display("FAIL timeout: %0d requests never completed, expected 0", timeouts);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1);
  end

  // Presents a request; lat < 0 skips the completion-cycle check.
  task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] v, input logic [31:0] exp_res, input int lat,
                       input bit push, output int c0);
    int n;
    @(negedge clk);
    #1;
    cache_valid = 1'b1;
    cache_wr    = wr;
    cache_size  = sz;
    cache_addr  = a;
    cache_value = v;
    c0 = cyc;
    if (push) begin
      exp_q.push_back('{res: exp_res, cyc: (lat < 0) ? -1 : c0 + lat});
      n = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
      if (wr) begin
        for (int k = 0; k < n; k++) begin
          logic [31:0] sh;
          sh = v >> (8 * k);
          wr_q.push_back('{cyc: c0 + 1 + k, a: a + k, d: sh[7:0]});
        end
      end
    end
  endtask

  // Waits for the completion pulse; valid stays high through the ready cycle.
  task automatic wait_ready();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cache_ready) got = 1'b1;
    end
    if (!got) timeouts++;
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    cache_valid = 1'b0;
  endtask

  initial begin
    int c0;
    int c1;
    mem[32'h100] = 8'h78;
    mem[32'h101] = 8'h56;
    mem[32'h102] = 8'h34;
    mem[32'h103] = 8'h12;
    mem[32'h10]  = 8'h80;
    repeat (3) @(negedge clk);
    #1 rst_in = 1'b0;

    issue(1'b0, 3'b010, 32'h100, 32'd0, 32'h12345678, 6, 1'b1, c0);
    wait_ready();
    idle();
    issue(1'b0, 3'b000, 32'h10, 32'd0, 32'hFFFFFF80, 3, 1'b1, c0);
    wait_ready();
    idle();
    issue(1'b0, 3'b100, 32'h10, 32'd0, 32'h00000080, 3, 1'b1, c0);
    wait_ready();
    idle();
    issue(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'd0, 3, 1'b1, c0);
    wait_ready();
    idle();
    issue(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'd0, 5, 1'b1, c0);
    wait_ready();
    issue(1'b0, 3'b010, 32'h40, 32'd0, 32'hDEADBEEF, 6, 1'b1, c0);
    wait_ready();
    idle();

    issue(1'b0, 3'b001, 32'h100, 32'd0, 32'h00005678, -1, 1'b1, c0);
    @(negedge clk);
    #1 rdy_in = 1'b0;
    repeat (2) @(negedge clk);
    #1 rdy_in = 1'b1;
    wait_ready();
    idle();

    issue(1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 0, 1'b0, c0);
    repeat (3) @(posedge clk);
    #1;
    rst_in      = 1'b1;
    cache_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_in = 1'b0;
    issue(1'b0, 3'b010, 32'h100, 32'd0, 32'h12345678, 6, 1'b1, c0);
    wait_ready();
    idle();

    io_buffer_full = 1'b1;
`ifdef IO_WRITE_STALL_EN
    issue(1'b1, 3'b000, 32'h30000, 32'h41, 32'd0, 0, 1'b0, c0);
    repeat (5) @(negedge clk);
    #1 io_buffer_full = 1'b0;
    c1 = cyc;
    exp_q.push_back('{res: 32'd0, cyc: c1 + 2});
    wr_q.push_back('{cyc: c1 + 1, a: 32'h30000, d: 8'h41});
`else
    issue(1'b1, 3'b000, 32'h30000, 32'h41, 32'd0, 2, 1'b1, c0);
    c1 = c0;
`endif
    wait_ready();
    idle();
    io_buffer_full = 1'b0;
    repeat (4) @(negedge clk);
    done = 1'b1;
  end

endmodule
